spi_burst_ctrl: RTL and testbench
=================================

// Module: spi_burst_ctrl
// PURPOSE
//  Sequencer for the SPI master path. On a host start it fetches a run of bytes from the 8x8 transmit memory,
//  frames them with chip select and shifts them out on mosi, LSB first.
//  Arbitrates memory ownership: the host memory port is granted only while the controller is idle.
//  Sits between the host-side memory block and the SPI pins.
// PARAMETERS
//  DATA_W   8  byte width; also the number of bits shifted per byte
//  ADDR_W   3  memory address width; depth is 2**ADDR_W and addresses wrap
//  CLK_DIV  2  sclk half-period in clk cycles (>=1); sclk = clk/(2*CLK_DIV)
// PORTS
//  clk         in   1       system clock
//  rst_n       in   1       asynchronous active-low reset
//  start       in   1       one-cycle pulse; accepted only in IDLE
//  start_addr  in   ADDR_W  first memory address of the burst
//  length      in   4       number of bytes, 0..15
//  abort       in   1       terminate the burst; cs_n deasserts next cycle
//  busy        out  1       high from the cycle after start until return to IDLE
//  done        out  1       one-cycle pulse when a burst completes normally
//  host_gnt    out  1       host owns memory = (state==IDLE)
//  mem_rd_en   out  1       memory read strobe; data returns the next cycle
//  mem_addr    out  ADDR_W  memory address
//  mem_rdata   in   DATA_W  memory read data
//  mem_wr_en   out  1       writeback strobe (macro-dependent)
//  mem_wdata   out  DATA_W  writeback data = received byte
//  sclk        out  1       SPI clock, mode 0, idle low
//  mosi        out  1       serial out, LSB first
//  miso        in   1       serial in, LSB first
//  cs_n        out  1       active-low chip select
// BEHAVIOUR
//  Reset values: cs_n=1, sclk=0, mosi=0, busy=0, done=0, mem_rd_en=0, mem_wr_en=0, mem_addr=0,
//  mem_wdata=0, host_gnt=1. Reset mid-burst aborts at once with no done pulse.
//  FSM: IDLE -> FETCH -> LOAD -> SHIFT -> NEXT -> (FETCH | DONE) -> IDLE.
//  IDLE: on start with length!=0, latch addr and count, then go to FETCH with cs_n=0 and busy=1.
//    start with length==0 goes to DONE directly: done pulses, cs_n never falls.
//  FETCH: 1 cycle, mem_rd_en=1, mem_addr=current address.
//  LOAD: 1 cycle; shift register <= mem_rdata; mosi=bit0.
//  SHIFT: 8 bits, each sclk low for CLK_DIV cycles then high for CLK_DIV cycles.
//    miso is sampled on the sclk rising edge; mosi advances on the falling edge.
//  NEXT: 1 cycle; address +1 mod 2**ADDR_W (7->0 wraps); count -1.
//    Go to FETCH if count!=0, else DONE.
//  DONE: cs_n=1, done=1 for exactly one cycle, busy=0 next cycle, return to IDLE.
//  Cycles per byte = 3 + 2*DATA_W*CLK_DIV. Bytes are back-to-back with no cs_n gap.
//  start while busy is ignored.
//  abort has priority over every state except IDLE: next cycle cs_n=1, sclk=0, IDLE, no done, no write.
//  abort and start in the same IDLE cycle: abort wins, start is dropped.
//  length 9..15 re-sends wrapped addresses; this is legal.
// CONFIGURATION
//  RX_WRITEBACK_EN defined: in NEXT, mem_wr_en=1 for 1 cycle; mem_wdata = received byte;
//    mem_addr = the address just sent (full-duplex capture).
//  Undefined: mem_wr_en is tied to 0 and mem_wdata to 0; miso is ignored.
// STRUCTURE
//  spi_ctrl_pkg holds: FSM state typedef (IDLE, FETCH, LOAD, SHIFT, NEXT, DONE),
//    DATA_W/ADDR_W defaults, and the LEN_W=4 constant.
//  Sub-module spi_sclk_gen: CLK_DIV counter producing sclk plus rise/fall strobes;
//    held low and reset while not in SHIFT.
// TESTING
//  1 mem[2]=8'hA5, start addr=2, len=1, CLK_DIV=2:
//    mosi=1,0,1,0,0,1,0,1 over 8 sclk; done 1 cycle; cs_n low 35 cycles.
//  2 addr=6, len=3, mem[6,7,0]=11,22,33: bytes sent 11,22,33; addr wraps 7->0; one continuous cs_n frame.
//  3 RX_WRITEBACK_EN, miso drives 8'h3C during byte at addr 4: mem_wr_en at addr 4, mem_wdata=8'h3C.
//  4 abort mid byte 2 of len=4: cs_n=1 next cycle, no done, host_gnt=1, no further mem_rd_en.
//  5 len=0 start: done next-cycle pulse, cs_n stays 1; start while busy: ignored, burst unchanged.
//  6 rst_n low during SHIFT: all outputs at reset values immediately; new start after release works.

Source files
------------

// File: rtl/spi_ctrl_pkg.sv
// rtl/spi_ctrl_pkg.sv - shared types and constants for the SPI burst controller
package spi_ctrl_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 3;
    localparam int LEN_W      = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        SHIFT = 3'd3,
        NEXT  = 3'd4,
        DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/spi_sclk_gen.sv
// rtl/spi_sclk_gen.sv - SPI clock divider with rise/fall strobes, held low while disabled
module spi_sclk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic sclk,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sclk_q, sclk_d;
    logic             wrap;

    // Strobes mark the clk edge on which sclk is about to change level.
    assign wrap = en && (cnt_q == CNT_LAST);
    assign rise = wrap && !sclk_q;
    assign fall = wrap && sclk_q;
    // Gating with en forces sclk low the very cycle the controller leaves SHIFT (abort).
    assign sclk = sclk_q && en;

    // Half-period counter; restarts from low phase whenever disabled.
    always_comb begin
        cnt_d  = cnt_q;
        sclk_d = sclk_q;
        if (!en) begin
            cnt_d  = '0;
            sclk_d = 1'b0;
        end else if (wrap) begin
            cnt_d  = '0;
            sclk_d = !sclk_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Divider state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

endmodule

// File: rtl/spi_burst_ctrl.sv
// rtl/spi_burst_ctrl.sv - SPI burst sequencer: memory fetch, framing, LSB-first shift; optional RX_WRITEBACK_EN
module spi_burst_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int CLK_DIV = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              host_gnt,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic              cs_n
);

    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  count_q, count_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic              in_shift;
    logic              sclk_rise;
    logic              sclk_fall;

    assign in_shift = (state_q == SHIFT);

    spi_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (in_shift),
        .sclk  (sclk),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    // All control outputs decode the registered state, so reset forces them immediately.
    assign busy      = (state_q != IDLE);
    assign host_gnt  = (state_q == IDLE);
    assign done      = (state_q == DONE);
    assign mem_rd_en = (state_q == FETCH);
    assign mem_addr  = addr_q;
    assign cs_n      = !((state_q == FETCH) || (state_q == LOAD) ||
                         (state_q == SHIFT) || (state_q == NEXT));
    // tx shifts right with zero fill, so mosi rests low once a byte is out.
    assign mosi      = tx_q[0];

    // Next-state and datapath updates; abort overrides everything outside IDLE.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    addr_d  = start_addr;
                    count_d = length;
                    state_d = (length != '0) ? FETCH : DONE;
                end
            end
            FETCH: state_d = LOAD;
            LOAD: begin
                tx_d    = mem_rdata;
                bit_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                if (sclk_fall) begin
                    tx_d = tx_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        state_d = NEXT;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            NEXT: begin
                addr_d  = addr_q + ADDR_W'(1);
                count_d = count_q - LEN_W'(1);
                state_d = (count_q != LEN_W'(1)) ? FETCH : DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            tx_d    = '0;
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            count_q <= '0;
            bit_q   <= '0;
            tx_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
        end
    end

`ifdef RX_WRITEBACK_EN
    logic [DATA_W-1:0] rx_q, rx_d;

    // Capture miso on each sclk rise, LSB first, into the top of the register.
    always_comb begin
        rx_d = rx_q;
        if (in_shift && sclk_rise) begin
            rx_d = {miso, rx_q[DATA_W-1:1]};
        end
    end

    // Receive shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_q <= '0;
        end else begin
            rx_q <= rx_d;
        end
    end

    // addr_q still holds the address just sent while in NEXT.
    assign mem_wr_en = (state_q == NEXT);
    assign mem_wdata = rx_q;
`else
    logic unused_miso;
    assign unused_miso = miso;
    assign mem_wr_en   = 1'b0;
    assign mem_wdata   = '0;
`endif

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// tb/tb_spi_burst_ctrl.sv - randomized self-checking bench for spi_burst_ctrl
module tb_spi_burst_ctrl;

    localparam int DW = 8;
    localparam int AW = 3;
    localparam int CD = 2;
    localparam int BYTE_CYC = 3 + 2 * DW * CD;
`ifdef RX_WRITEBACK_EN
    localparam bit WB = 1'b1;
`else
    localparam bit WB = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          miso = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [3:0]    length = '0;
    logic          busy, done, host_gnt, mem_rd_en, mem_wr_en, sclk, mosi, cs_n;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;
    logic [DW-1:0] mem_wdata;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    spi_burst_ctrl #(.DATA_W(DW), .ADDR_W(AW), .CLK_DIV(CD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .length     (length),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .host_gnt   (host_gnt),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_wr_en  (mem_wr_en),
        .mem_wdata  (mem_wdata),
        .sclk       (sclk),
        .mosi       (mosi),
        .miso       (miso),
        .cs_n       (cs_n)
    );

    // Transmit memory: one-cycle read latency, writeback port.
    logic [7:0] mem [8];
    logic [7:0] snap [8];
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
        if (mem_wr_en) mem[mem_addr] = mem_wdata;
    end

    // Pin-level monitor and SPI slave.
    int         done_cnt, cs_low, frames, rx_bit;
    bit         prev_sclk = 1'b0;
    bit         prev_cs = 1'b1;
    logic [7:0] miso_byte = 8'h00;
    bit         bits [$];
    logic [2:0] rd_q [$];
    logic [10:0] wr_q [$];
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (!cs_n) cs_low++;
        if (prev_cs && !cs_n) frames++;
        if (sclk && !prev_sclk) begin
            bits.push_back(mosi);
            rx_bit = (rx_bit + 1) % 8;
            miso = miso_byte[rx_bit];
        end
        if (mem_rd_en) rd_q.push_back(mem_addr);
        if (mem_wr_en) wr_q.push_back({mem_addr, mem_wdata});
        prev_sclk = sclk;
        prev_cs = cs_n;
    end

    function automatic logic [7:0] got_byte(int k);
        logic [7:0] b;
        b = 'x;
        for (int j = 0; j < 8; j++) if (8 * k + j < bits.size()) b[j] = bits[8 * k + j];
        return b;
    endfunction

    // Reference: byte i of a burst comes from address (a+i) mod 8 as it stood
    // before the burst, unless writeback already replaced it on an earlier pass.
    function automatic logic [7:0] model_byte(logic [2:0] a, int i, logic [7:0] mb);
        if (WB && i >= 8) return mb;
        return snap[(int'(a) + i) % 8];
    endfunction

    task automatic clear_mon();
        done_cnt = 0; cs_low = 0; frames = 0; rx_bit = 0;
        bits.delete(); rd_q.delete(); wr_q.delete();
    endtask

    task automatic run_burst(input logic [2:0] a, input int len, input logic [7:0] mb);
        int n;
        clear_mon();
        miso_byte = mb;
        miso = mb[0];
        snap = mem;
        @(negedge clk);
        start = 1'b1; start_addr = a; length = len[3:0];
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy && n < 3000) begin @(negedge clk); n++; end
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL burst_timeout busy=%b required 0", busy);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        total_cnt++;
        if ({cs_n, sclk, mosi, busy, done, mem_rd_en, mem_wr_en, host_gnt} !== 8'b1000_0001)
            $display("FAIL reset_ctrl got=%b required 10000001",
                     {cs_n, sclk, mosi, busy, done, mem_rd_en, mem_wr_en, host_gnt});
        else pass_cnt++;
        total_cnt++;
        if ({mem_addr, mem_wdata} !== 11'h0) $display("FAIL reset_mem got=%h required 0", {mem_addr, mem_wdata});
        else pass_cnt++;
    endtask

    task automatic test_single();
        mem[2] = 8'hA5;
        run_burst(3'd2, 1, 8'h00);
        total_cnt++;
        if (got_byte(0) !== 8'hA5 || bits.size() != 8) $display("FAIL single_mosi got=%h/%0d bits required a5/8", got_byte(0), bits.size());
        else pass_cnt++;
        total_cnt++;
        if (done_cnt !== 1) $display("FAIL single_done got=%0d required 1", done_cnt);
        else pass_cnt++;
        total_cnt++;
        if (cs_low !== 35 || frames !== 1) $display("FAIL single_cs got=%0d/%0d required 35/1", cs_low, frames);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        mem[6] = 8'h11; mem[7] = 8'h22; mem[0] = 8'h33;
        run_burst(3'd6, 3, 8'h5A);
        total_cnt++;
        if ({got_byte(0), got_byte(1), got_byte(2)} !== 24'h112233)
            $display("FAIL wrap_bytes got=%h required 112233", {got_byte(0), got_byte(1), got_byte(2)});
        else pass_cnt++;
        total_cnt++;
        if (rd_q.size() != 3 || rd_q[0] !== 3'd6 || rd_q[1] !== 3'd7 || rd_q[2] !== 3'd0)
            $display("FAIL wrap_addr got_count=%0d required 6,7,0", rd_q.size());
        else pass_cnt++;
        total_cnt++;
        if (frames !== 1 || cs_low !== 3 * BYTE_CYC) $display("FAIL wrap_frame got=%0d/%0d required 1/%0d", frames, cs_low, 3 * BYTE_CYC);
        else pass_cnt++;
    endtask

    task automatic test_writeback();
        mem[4] = 8'hC7;
        run_burst(3'd4, 1, 8'h3C);
        total_cnt++;
        if (WB) begin
            if (wr_q.size() != 1 || wr_q[0] !== {3'd4, 8'h3C}) $display("FAIL wb_write count=%0d required 1 at 4 data 3c", wr_q.size());
            else pass_cnt++;
        end else begin
            if (wr_q.size() != 0) $display("FAIL wb_write count=%0d required 0", wr_q.size());
            else pass_cnt++;
        end
        total_cnt++;
        if (mem[4] !== (WB ? 8'h3C : 8'hC7)) $display("FAIL wb_mem got=%h required %h", mem[4], WB ? 8'h3C : 8'hC7);
        else pass_cnt++;
    endtask

    task automatic test_abort();
        int n;
        clear_mon();
        for (int i = 0; i < 8; i++) mem[i] = 8'($urandom);
        @(negedge clk);
        start = 1'b1; abort = 1'b1; start_addr = 3'd0; length = 4'd4;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        total_cnt++;
        if (busy !== 1'b0 || host_gnt !== 1'b1) $display("FAIL abort_start_same busy=%b gnt=%b required 0/1", busy, host_gnt);
        else pass_cnt++;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (rd_q.size() < 2 && n < 500) begin @(negedge clk); n++; end
        total_cnt++;
        if (rd_q.size() < 2) $display("FAIL abort_wait reads=%0d required 2", rd_q.size());
        else pass_cnt++;
        repeat (10) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        total_cnt++;
        if ({cs_n, sclk, busy, host_gnt} !== 4'b1001) $display("FAIL abort_next got=%b required 1001", {cs_n, sclk, busy, host_gnt});
        else pass_cnt++;
        repeat (80) @(negedge clk);
        total_cnt++;
        if (rd_q.size() != 2 || done_cnt != 0 || wr_q.size() != (WB ? 1 : 0))
            $display("FAIL abort_after reads=%0d done=%0d writes=%0d required 2/0/%0d", rd_q.size(), done_cnt, wr_q.size(), WB ? 1 : 0);
        else pass_cnt++;
    endtask

    task automatic test_zero_len();
        clear_mon();
        @(negedge clk);
        start = 1'b1; start_addr = 3'd3; length = 4'd0;
        @(negedge clk);
        start = 1'b0;
        total_cnt++;
        if ({done, busy, cs_n} !== 3'b111) $display("FAIL zero_done got=%b required 111", {done, busy, cs_n});
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({done, busy, cs_n} !== 3'b001 || frames != 0 || rd_q.size() != 0)
            $display("FAIL zero_after got=%b frames=%0d required 001/0", {done, busy, cs_n}, frames);
        else pass_cnt++;
    endtask

    task automatic test_start_busy();
        int n;
        clear_mon();
        for (int i = 0; i < 8; i++) mem[i] = 8'($urandom);
        snap = mem;
        miso_byte = 8'h00; miso = 1'b0;
        @(negedge clk);
        start = 1'b1; start_addr = 3'd1; length = 4'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        start = 1'b1; start_addr = 3'd5; length = 4'd7;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy && n < 3000) begin @(negedge clk); n++; end
        @(negedge clk);
        total_cnt++;
        if (bits.size() != 16 || got_byte(0) !== snap[1] || got_byte(1) !== snap[2] || rd_q.size() != 2 || done_cnt != 1)
            $display("FAIL start_busy bits=%0d bytes=%h%h required 16 bytes %h%h", bits.size(), got_byte(0), got_byte(1), snap[1], snap[2]);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int n;
        clear_mon();
        @(negedge clk);
        start = 1'b1; start_addr = 3'd5; length = 4'd3;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (bits.size() < 3 && n < 500) begin @(negedge clk); n++; end
        #1 rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({cs_n, sclk, mosi, busy, done, mem_rd_en, mem_wr_en, host_gnt, mem_addr, mem_wdata} !== {8'b1000_0001, 11'h0})
            $display("FAIL reset_mid got=%b required 1000000100000000000",
                     {cs_n, sclk, mosi, busy, done, mem_rd_en, mem_wr_en, host_gnt, mem_addr, mem_wdata});
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (done_cnt != 0) $display("FAIL reset_mid_done got=%0d required 0", done_cnt);
        else pass_cnt++;
        mem[0] = 8'h96;
        run_burst(3'd0, 1, 8'h00);
        total_cnt++;
        if (got_byte(0) !== 8'h96 || done_cnt != 1) $display("FAIL reset_mid_restart got=%h required 96", got_byte(0));
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [2:0] a;
        logic [7:0] mb;
        int len;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 8; i++) mem[i] = 8'($urandom);
            a = 3'($urandom);
            mb = 8'($urandom);
            len = (r == 0) ? 15 : $urandom_range(1, 12);
            run_burst(a, len, mb);
            for (int k = 0; k < len; k++) begin
                total_cnt++;
                if (got_byte(k) !== model_byte(a, k, mb))
                    $display("FAIL rand_byte r=%0d k=%0d got=%h required %h", r, k, got_byte(k), model_byte(a, k, mb));
                else pass_cnt++;
            end
            total_cnt++;
            if (cs_low != len * BYTE_CYC || frames != 1 || done_cnt != 1 || rd_q.size() != len || wr_q.size() != (WB ? len : 0))
                $display("FAIL rand_frame r=%0d cs=%0d frames=%0d done=%0d reads=%0d writes=%0d required %0d/1/1/%0d",
                         r, cs_low, frames, done_cnt, rd_q.size(), wr_q.size(), len * BYTE_CYC, len);
            else pass_cnt++;
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
        clear_mon();
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_single();
        test_wrap();
        test_writeback();
        test_abort();
        test_zero_len();
        test_start_busy();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
